ws2812_rx: RTL and testbench
============================

WS2812_RX -- requirements
Module: ws2812_rx

Interface
REQ-001 SHALL have parameter MIN_HIGH, default 8: a high pulse shorter than this many clocks is a glitch.
REQ-002 SHALL have parameter BIT_THRESH, default 48: a high pulse of this many clocks or more decodes as bit 1, shorter as bit 0 (0.6 us at 80 MHz).
REQ-003 SHALL have parameter MAX_HIGH, default 120: a high pulse longer than this many clocks is an error.
REQ-004 SHALL have parameter RST_CYCLES, default 4000: a low time of this many clocks is a latch gap (50 us).
REQ-005 SHALL have port clk_in, input, 1 bit: the single clock, rising-edge, sys_clk domain.
REQ-006 SHALL have port rst_n_in, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port ws2812_data_in, input, 1 bit: asynchronous single-wire WS2812 NRZ stream.
REQ-008 SHALL have port pixel_rdy_out, output, 1 bit: one-cycle pulse when a pixel word is valid.
REQ-009 SHALL have port pixel_data_out, output, 24 bits: last decoded pixel, first bit received in bit 23 (GRB order).
REQ-010 SHALL have port frame_rdy_out, output, 1 bit: one-cycle pulse at a latch gap that follows at least one bit.
REQ-011 SHALL have port frame_len_out, output, 10 bits: pixel count of the last completed frame.
REQ-012 SHALL have port err_out, output, 1 bit: one-cycle pulse on a protocol error.

Function
REQ-013 SHALL pass ws2812_data_in through a 2-flop synchronizer plus one edge-detect register; all timing below refers to the synchronized signal.
REQ-014 SHALL implement states RESYNC, WAIT_HIGH, MEAS_HIGH and MEAS_LOW, plus a 12-bit saturating pulse-width counter.
REQ-015 RESYNC: SHALL count consecutive low clocks, restart the count on any high, and go to WAIT_HIGH when the count reaches RST_CYCLES, without pulsing frame_rdy_out.
REQ-016 WAIT_HIGH: on a rising edge, SHALL clear the counter and go to MEAS_HIGH.
REQ-017 MEAS_HIGH: SHALL count high clocks.
REQ-018 MEAS_HIGH: when the count exceeds MAX_HIGH, SHALL pulse err_out, discard the partial pixel and frame, and go to RESYNC.
REQ-019 MEAS_HIGH: on a falling edge with count < MIN_HIGH, SHALL pulse err_out, discard the partial pixel and go to RESYNC.
REQ-020 MEAS_HIGH: on a falling edge otherwise, SHALL shift bit (count >= BIT_THRESH) into a 24-bit shift register, increment the 5-bit bit index, and go to MEAS_LOW.
REQ-021 On the 24th bit, SHALL load pixel_data_out and pulse pixel_rdy_out in the clock after the synchronized falling edge, clear the bit index, and increment the frame pixel counter, saturating at 1023.
REQ-022 MEAS_LOW: SHALL count low clocks and go to MEAS_HIGH on a rising edge.
REQ-023 MEAS_LOW: when the count reaches RST_CYCLES, SHALL pulse frame_rdy_out, load frame_len_out from the pixel counter, clear the pixel counter, and go to WAIT_HIGH.
REQ-024 MEAS_LOW: if the bit index is nonzero at the latch gap, SHALL also pulse err_out in the same cycle and discard the partial bits.
REQ-025 SHALL not constrain the low time of a bit between bits; only a gap of RST_CYCLES or more ends a frame.
REQ-026 SHALL not let the counter wrap; it saturates at 4095.
REQ-027 SHALL hold pixel_data_out and frame_len_out stable between their load events.
REQ-028 SHALL give priority to the 24th-bit pixel_rdy_out over error handling when both occur in one cycle; errors can only occur in later cycles.

Reset
REQ-029 On rst_n_in low, SHALL asynchronously return to RESYNC with all counters, the shift register, the synchronizer flops, pixel_data_out and frame_len_out at 0.
REQ-030 While rst_n_in is low, SHALL hold all pulse outputs at 0.
REQ-031 If reset is asserted mid-frame, SHALL drop the partial frame silently; after release it SHALL emit no pixel_rdy_out until a full RST_CYCLES low gap has been seen.

Structure
REQ-032 SHALL take the timing defaults (MIN_HIGH, BIT_THRESH, MAX_HIGH, RST_CYCLES) and the counter widths from the shared ws2812_pkg package, which the transmit side also uses.
REQ-033 SHALL instantiate exactly one sub-module, sync_edge (synchronizer plus rise/fall pulse generation); the FSM and datapath SHALL be inline.

Verification
REQ-034 Scenario 1: low for 4000 clocks, then 24 bits of 0xA5C33C (1 = 64 clocks high / 36 low, 0 = 32 high / 68 low), then low for 4000 clocks -> exactly one pixel_rdy_out with pixel_data_out = 0xA5C33C, then frame_rdy_out with frame_len_out = 1, and err_out never asserted.
REQ-035 Scenario 2: 300 back-to-back pixels followed by a gap -> 300 pixel_rdy_out pulses, then frame_len_out = 300.
REQ-036 Scenario 3: a 5-clock high glitch at bit 7 -> err_out pulse; no pixel_rdy_out until after the next 4000-clock low.
REQ-037 Scenario 4: a 200-clock high pulse -> err_out on the 121st high clock and state RESYNC.
REQ-038 Scenario 5: 12 bits followed by a 4000-clock gap -> frame_rdy_out and err_out in the same cycle, with frame_len_out = 0.
REQ-039 Scenario 6: rst_n_in pulsed low at bit 10 of pixel 2 -> all outputs 0 immediately; a stream resumed without a gap -> no pixel_rdy_out.

Source files
------------

// File: rtl/ws2812_pkg.sv
// Shared WS2812 timing defaults, counter widths and receiver state encoding.
// Used by both the receive and transmit sides of the LED link.
package ws2812_pkg;

  localparam int unsigned WS_MIN_HIGH   = 8;
  localparam int unsigned WS_BIT_THRESH = 48;
  localparam int unsigned WS_MAX_HIGH   = 120;
  localparam int unsigned WS_RST_CYCLES = 4000;

  localparam int unsigned CNT_W = 12;
  localparam int unsigned IDX_W = 5;
  localparam int unsigned LEN_W = 10;
  localparam int unsigned PIX_W = 24;

  typedef enum logic [1:0] {
    RESYNC,
    WAIT_HIGH,
    MEAS_HIGH,
    MEAS_LOW
  } rx_state_e;

  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [LEN_W-1:0] sat_inc_len(input logic [LEN_W-1:0] v);
    return (&v) ? v : v + LEN_W'(1);
  endfunction

endpackage

// File: rtl/ws2812_rx_sync_edge.sv
// Two-flop synchronizer for the asynchronous data line plus an edge-detect
// register producing single-cycle rise/fall strobes on the synchronized level.
module sync_edge (
  input  logic clk_in,
  input  logic rst_n_in,
  input  logic async_in,
  output logic level_out,
  output logic rise_out,
  output logic fall_out
);

  logic [1:0] sync_q;
  logic       prev_q;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      sync_q <= 2'b00;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], async_in};
      prev_q <= sync_q[1];
    end
  end

  assign level_out = sync_q[1];
  assign rise_out  = sync_q[1] & ~prev_q;
  assign fall_out  = ~sync_q[1] & prev_q;

endmodule

// File: rtl/ws2812_rx.sv
// WS2812 NRZ receiver: measures high/low pulse widths on the synchronized line,
// assembles 24-bit GRB pixels and reports frame length at each latch gap.
module ws2812_rx
  import ws2812_pkg::*;
#(
  parameter int unsigned MIN_HIGH   = WS_MIN_HIGH,
  parameter int unsigned BIT_THRESH = WS_BIT_THRESH,
  parameter int unsigned MAX_HIGH   = WS_MAX_HIGH,
  parameter int unsigned RST_CYCLES = WS_RST_CYCLES
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             ws2812_data_in,
  output logic             pixel_rdy_out,
  output logic [PIX_W-1:0] pixel_data_out,
  output logic             frame_rdy_out,
  output logic [LEN_W-1:0] frame_len_out,
  output logic             err_out
);

  localparam logic [CNT_W-1:0] MIN_HIGH_C   = CNT_W'(MIN_HIGH);
  localparam logic [CNT_W-1:0] BIT_THRESH_C = CNT_W'(BIT_THRESH);
  localparam logic [CNT_W-1:0] MAX_HIGH_C   = CNT_W'(MAX_HIGH);
  localparam logic [CNT_W-1:0] RST_C        = CNT_W'(RST_CYCLES);
  localparam logic [IDX_W-1:0] LAST_IDX_C   = IDX_W'(PIX_W - 1);

  logic level, rise, fall;

  sync_edge u_sync_edge (
    .clk_in    (clk_in),
    .rst_n_in  (rst_n_in),
    .async_in  (ws2812_data_in),
    .level_out (level),
    .rise_out  (rise),
    .fall_out  (fall)
  );

  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PIX_W-1:0] shift_q, shift_d;
  logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
  logic [LEN_W-1:0] pix_cnt_q, pix_cnt_d;
  logic [PIX_W-1:0] pixel_q, pixel_d;
  logic [LEN_W-1:0] frame_len_q, frame_len_d;
  logic             pixel_rdy_q, pixel_rdy_d;
  logic             frame_rdy_q, frame_rdy_d;
  logic             err_q, err_d;

  // The counter value once the current clock is included; the edge clocks
  // themselves are counted as the first clock of the new level.
  logic [CNT_W-1:0] cnt_inc;
  logic             too_long, glitch, bit_val, gap, resync_done;

  assign cnt_inc     = sat_inc_cnt(cnt_q);
  assign too_long    = (state_q == MEAS_HIGH) && level && (cnt_inc > MAX_HIGH_C);
  assign glitch      = (state_q == MEAS_HIGH) && fall && (cnt_q < MIN_HIGH_C);
  assign bit_val     = (cnt_q >= BIT_THRESH_C);
  assign gap         = (state_q == MEAS_LOW) && !level && (cnt_inc >= RST_C);
  assign resync_done = (state_q == RESYNC) && !level && (cnt_inc >= RST_C);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state_q <= RESYNC;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RESYNC:    if (resync_done) state_d = WAIT_HIGH;
      WAIT_HIGH: if (rise) state_d = MEAS_HIGH;
      MEAS_HIGH: begin
        if (too_long || glitch) state_d = RESYNC;
        else if (fall)          state_d = MEAS_LOW;
      end
      MEAS_LOW: begin
        if (rise)     state_d = MEAS_HIGH;
        else if (gap) state_d = WAIT_HIGH;
      end
      default:   state_d = RESYNC;
    endcase
  end

  // Datapath and pulse outputs; any frame in progress while resynchronizing is dropped.
  always_comb begin
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    bit_idx_d   = bit_idx_q;
    pix_cnt_d   = pix_cnt_q;
    pixel_d     = pixel_q;
    frame_len_d = frame_len_q;
    pixel_rdy_d = 1'b0;
    frame_rdy_d = 1'b0;
    err_d       = 1'b0;
    unique case (state_q)
      RESYNC: begin
        cnt_d     = level ? '0 : cnt_inc;
        pix_cnt_d = '0;
        bit_idx_d = '0;
        shift_d   = '0;
      end
      WAIT_HIGH: begin
        if (rise) cnt_d = CNT_W'(1);
      end
      MEAS_HIGH: begin
        if (too_long) begin
          err_d     = 1'b1;
          cnt_d     = '0;
          bit_idx_d = '0;
          shift_d   = '0;
          pix_cnt_d = '0;
        end else if (glitch) begin
          err_d     = 1'b1;
          cnt_d     = '0;
          bit_idx_d = '0;
          shift_d   = '0;
        end else if (fall) begin
          cnt_d   = CNT_W'(1);
          shift_d = {shift_q[PIX_W-2:0], bit_val};
          if (bit_idx_q == LAST_IDX_C) begin
            pixel_d     = {shift_q[PIX_W-2:0], bit_val};
            pixel_rdy_d = 1'b1;
            bit_idx_d   = '0;
            pix_cnt_d   = sat_inc_len(pix_cnt_q);
          end else begin
            bit_idx_d = bit_idx_q + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end
      MEAS_LOW: begin
        if (rise) begin
          cnt_d = CNT_W'(1);
        end else begin
          cnt_d = cnt_inc;
          if (gap) begin
            frame_rdy_d = 1'b1;
            frame_len_d = pix_cnt_q;
            pix_cnt_d   = '0;
            err_d       = (bit_idx_q != '0);
            bit_idx_d   = '0;
            shift_d     = '0;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cnt_q       <= '0;
      shift_q     <= '0;
      bit_idx_q   <= '0;
      pix_cnt_q   <= '0;
      pixel_q     <= '0;
      frame_len_q <= '0;
      pixel_rdy_q <= 1'b0;
      frame_rdy_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      bit_idx_q   <= bit_idx_d;
      pix_cnt_q   <= pix_cnt_d;
      pixel_q     <= pixel_d;
      frame_len_q <= frame_len_d;
      pixel_rdy_q <= pixel_rdy_d;
      frame_rdy_q <= frame_rdy_d;
      err_q       <= err_d;
    end
  end

  assign pixel_rdy_out  = pixel_rdy_q;
  assign pixel_data_out = pixel_q;
  assign frame_rdy_out  = frame_rdy_q;
  assign frame_len_out  = frame_len_q;
  assign err_out        = err_q;

endmodule

// File: tb/tb_ws2812_rx.sv
// Scoreboard bench for ws2812_rx using shortened timing parameters so that
// long frames fit in a short run; expected pixels/frames are queued as driven.
module tb_ws2812_rx;

  localparam int MIN_HIGH   = 2;
  localparam int BIT_THRESH = 4;
  localparam int MAX_HIGH   = 8;
  localparam int RST_CYCLES = 40;
  localparam int ONE_HI     = 5;
  localparam int ONE_LO     = 2;
  localparam int ZERO_HI    = 3;
  localparam int ZERO_LO    = 4;
  localparam int GAP        = RST_CYCLES + 10;

  typedef struct {
    logic [9:0] len;
    logic       err;
  } frameExp_t;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic        dataIn = 1'b0;
  logic        pixelRdy, frameRdy, errOut;
  logic [23:0] pixelData;
  logic [9:0]  frameLen;

  int assertCount = 0;
  int failCount = 0;
  int errSeen = 0;
  int errExpected = 0;

  logic [23:0] pixQ[$];
  frameExp_t   frameQ[$];

  ws2812_rx #(
    .MIN_HIGH   (MIN_HIGH),
    .BIT_THRESH (BIT_THRESH),
    .MAX_HIGH   (MAX_HIGH),
    .RST_CYCLES (RST_CYCLES)
  ) dut (
    .clk_in         (clk),
    .rst_n_in       (rstN),
    .ws2812_data_in (dataIn),
    .pixel_rdy_out  (pixelRdy),
    .pixel_data_out (pixelData),
    .frame_rdy_out  (frameRdy),
    .frame_len_out  (frameLen),
    .err_out        (errOut)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Output monitor: every pulse is matched against the head of its queue.
  always @(negedge clk) begin
    if (rstN) begin
      if (errOut) errSeen++;
      if (pixelRdy) begin
        if (pixQ.size() == 0) begin
          checkOutput("pixel_rdy_unexpected", 32'(pixelRdy), 32'd0);
        end else begin
          logic [23:0] expPix;
          expPix = pixQ.pop_front();
          checkOutput("pixel_data", 32'(pixelData), 32'(expPix));
        end
      end
      if (frameRdy) begin
        if (frameQ.size() == 0) begin
          checkOutput("frame_rdy_unexpected", 32'(frameRdy), 32'd0);
        end else begin
          frameExp_t expFrame;
          expFrame = frameQ.pop_front();
          checkOutput("frame_len", 32'(frameLen), 32'(expFrame.len));
          checkOutput("frame_err", 32'(errOut), 32'(expFrame.err));
        end
      end
    end
  end

  task automatic driveLevel(input logic lvl, input int n);
    dataIn = lvl;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sendBit(input int hi, input int lo);
    driveLevel(1'b1, hi);
    driveLevel(1'b0, lo);
  endtask

  task automatic sendBits(input logic [23:0] p, input int first, input int last);
    for (int i = first; i >= last; i--) begin
      if (p[i]) sendBit(ONE_HI, ONE_LO);
      else      sendBit(ZERO_HI, ZERO_LO);
    end
  endtask

  task automatic applyStimulus(input logic [23:0] p, input bit expectIt);
    if (expectIt) pixQ.push_back(p);
    sendBits(p, 23, 0);
  endtask

  task automatic pushFrame(input int len, input bit err);
    frameExp_t f;
    f.len = 10'(len);
    f.err = err;
    frameQ.push_back(f);
  endtask

  task automatic endScenario(input string tag);
    driveLevel(1'b0, GAP);
    checkOutput({tag, "_pix_pending"}, 32'(pixQ.size()), 32'd0);
    checkOutput({tag, "_frame_pending"}, 32'(frameQ.size()), 32'd0);
    checkOutput({tag, "_err_count"}, 32'(errSeen), 32'(errExpected));
  endtask

  task automatic checkQuiet(input string tag);
    checkOutput({tag, "_pixel_data"}, 32'(pixelData), 32'd0);
    checkOutput({tag, "_frame_len"}, 32'(frameLen), 32'd0);
    checkOutput({tag, "_pulses"}, {29'd0, pixelRdy, frameRdy, errOut}, 32'd0);
  endtask

  initial begin
    int errAt;

    $display("[TB] start");
    repeat (3) @(posedge clk);
    #1;
    checkQuiet("reset");
    rstN = 1'b1;

    // Scenario 1: single pixel frame after an initial latch gap.
    driveLevel(1'b0, GAP);
    pushFrame(1, 1'b0);
    applyStimulus(24'hA5C33C, 1'b1);
    endScenario("s1");
    checkOutput("s1_pixel_hold", 32'(pixelData), 32'h00A5C33C);
    checkOutput("s1_len_hold", 32'(frameLen), 32'd1);

    // Pulse-width boundaries: MIN_HIGH and BIT_THRESH-1 give 0, BIT_THRESH and MAX_HIGH give 1.
    pixQ.push_back(24'h333333);
    pushFrame(1, 1'b0);
    for (int r = 0; r < 6; r++) begin
      sendBit(MIN_HIGH, 3);
      sendBit(BIT_THRESH - 1, 3);
      sendBit(BIT_THRESH, 3);
      sendBit(MAX_HIGH, 3);
    end
    endScenario("s1b");

    // Scenario 2: long frame of back-to-back pixels.
    pushFrame(300, 1'b0);
    for (int n = 0; n < 300; n++) applyStimulus(24'($urandom()), 1'b1);
    endScenario("s2");
    checkOutput("s2_len_hold", 32'(frameLen), 32'd300);

    // Scenario 3: glitch at bit 7; stream ignored until the next latch gap.
    sendBits(24'hFFFFFF, 23, 17);
    sendBit(1, 2);
    errExpected++;
    sendBits(24'hFFFFFF, 16, 0);
    applyStimulus(24'h0F0F0F, 1'b0);
    endScenario("s3");
    pushFrame(1, 1'b0);
    applyStimulus(24'h5AA55A, 1'b1);
    endScenario("s3b");

    // Scenario 4: over-long high pulse, first error two sync clocks plus one register after the limit.
    errAt = 0;
    dataIn = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (errOut && errAt == 0) errAt = n;
    end
    @(posedge clk);
    #1;
    errExpected++;
    checkOutput("s4_err_cycle", 32'(errAt), 32'(MAX_HIGH + 3));
    driveLevel(1'b0, 2);
    applyStimulus(24'h00FF00, 1'b0);
    endScenario("s4");
    pushFrame(1, 1'b0);
    applyStimulus(24'hC0FFEE, 1'b1);
    endScenario("s4b");

    // Scenario 5: partial pixel at the gap reports error together with the frame.
    errExpected++;
    pushFrame(0, 1'b1);
    sendBits(24'hABCDEF, 23, 12);
    endScenario("s5");

    // Scenario 6: reset during bit 10 of pixel 2, then stream resumes with no gap.
    applyStimulus(24'h123456, 1'b1);
    sendBits(24'h654321, 23, 14);
    driveLevel(1'b1, 2);
    rstN = 1'b0;
    #1;
    checkQuiet("s6_rst_now");
    repeat (3) @(posedge clk);
    #1;
    checkQuiet("s6_rst_hold");
    rstN = 1'b1;
    driveLevel(1'b1, 2);
    driveLevel(1'b0, ONE_LO);
    sendBits(24'h654321, 12, 0);
    applyStimulus(24'h777777, 1'b0);
    applyStimulus(24'h888888, 1'b0);
    endScenario("s6");
    pushFrame(1, 1'b0);
    applyStimulus(24'h3C3C3C, 1'b1);
    endScenario("s6b");

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
